// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset instruction, opcodes and the
// fetch FSM state encoding.
package cpu_pkg;

  localparam int PC_W = 8;
  localparam int INST_W = 16;
  localparam logic [15:0] NOP_INST = 16'hF000;

  localparam logic [3:0] OP_JMP = 4'b1011;
  localparam logic [3:0] OP_LDI = 4'b1100;
  localparam logic [3:0] OP_NOP = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] inst);
    return inst[15:12];
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with its next-value selection.
// Priority is branch, then increment, then hold.
module pc_reg #(
  parameter int PC_W = cpu_pkg::PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_en,
  input  logic [PC_W-1:0] branch_target,
  input  logic            inc_en,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_next_s;

  // Next PC: branch beats increment; addition wraps modulo 2^PC_W
  always_comb begin
    pc_next_s = pc_r;
    if (branch_en) begin
      pc_next_s = branch_target;
    end else if (inc_en) begin
      pc_next_s = pc_r + PC_W'(1);
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC state register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= '0;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory read per ir_ld, holds
// the IR, and defers PC advance/branch until the outstanding read completes.
module fetch_unit #(
  parameter int                PC_W     = cpu_pkg::PC_W,
  parameter int                INST_W   = cpu_pkg::INST_W,
  parameter logic [INST_W-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_ld,
  input  logic              ir_ld,
  input  logic              pc_branch,
  input  logic [PC_W-1:0]   branch_addr,
  input  logic              flush,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   pc,
  output logic              inst_valid,
  output logic              stall
);

  import cpu_pkg::*;

  fetch_state_e      state_r, state_next_s;
  logic [PC_W-1:0]   imem_addr_r, imem_addr_next_s;
  logic [INST_W-1:0] ir_r, ir_next_s;
  logic              inst_valid_r, inst_valid_next_s;
  logic              inc_pend_r, inc_pend_next_s;
  logic              br_pend_r, br_pend_next_s;
  logic [PC_W-1:0]   br_addr_r, br_addr_next_s;
  logic              drop_r, drop_next_s;
  logic              pc_branch_en_s;
  logic [PC_W-1:0]   pc_branch_tgt_s;
  logic              pc_inc_en_s;
  logic [PC_W-1:0]   pc_s;

  pc_reg #(.PC_W(PC_W)) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .branch_en    (pc_branch_en_s),
    .branch_target(pc_branch_tgt_s),
    .inc_en       (pc_inc_en_s),
    .pc           (pc_s)
  );

  // Next-state, pending-request bookkeeping and PC control
  always_comb begin
    state_next_s      = state_r;
    imem_addr_next_s  = imem_addr_r;
    ir_next_s         = ir_r;
    inst_valid_next_s = inst_valid_r;
    inc_pend_next_s   = inc_pend_r;
    br_pend_next_s    = br_pend_r;
    br_addr_next_s    = br_addr_r;
    drop_next_s       = drop_r;
    pc_branch_en_s    = 1'b0;
    pc_branch_tgt_s   = branch_addr;
    pc_inc_en_s       = 1'b0;

    case (state_r)
      IDLE: begin
        if (flush) begin
          ir_next_s         = NOP_INST;
          inst_valid_next_s = 1'b0;
        end else begin
          ir_next_s         = ir_r;
        end
        if (ir_ld && !flush) begin
          // PC requests raised with the fetch are applied when it completes
          state_next_s     = BUSY;
          imem_addr_next_s = pc_s;
          inc_pend_next_s  = pc_ld;
          br_pend_next_s   = pc_branch;
          br_addr_next_s   = branch_addr;
          drop_next_s      = 1'b0;
        end else begin
          pc_branch_en_s = pc_branch;
          pc_inc_en_s    = pc_ld;
        end
      end
      BUSY: begin
        if (pc_branch) begin
          br_pend_next_s = 1'b1;
          br_addr_next_s = branch_addr;
        end else begin
          br_pend_next_s = br_pend_r;
        end
        if (flush) begin
          drop_next_s = 1'b1;
        end else begin
          drop_next_s = drop_r;
        end
        if (imem_ack) begin
          state_next_s = IDLE;
          if (drop_r || flush) begin
            ir_next_s         = NOP_INST;
            inst_valid_next_s = 1'b0;
          end else begin
            ir_next_s         = imem_rdata;
            inst_valid_next_s = 1'b1;
          end
          pc_branch_en_s  = br_pend_next_s;
          pc_branch_tgt_s = br_addr_next_s;
          pc_inc_en_s     = inc_pend_r;
          inc_pend_next_s = 1'b0;
          br_pend_next_s  = 1'b0;
          drop_next_s     = 1'b0;
        end else begin
          state_next_s = BUSY;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Fetch state, IR and pending-request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      imem_addr_r  <= '0;
      ir_r         <= NOP_INST;
      inst_valid_r <= 1'b0;
      inc_pend_r   <= 1'b0;
      br_pend_r    <= 1'b0;
      br_addr_r    <= '0;
      drop_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      imem_addr_r  <= imem_addr_next_s;
      ir_r         <= ir_next_s;
      inst_valid_r <= inst_valid_next_s;
      inc_pend_r   <= inc_pend_next_s;
      br_pend_r    <= br_pend_next_s;
      br_addr_r    <= br_addr_next_s;
      drop_r       <= drop_next_s;
    end
  end

  assign imem_req   = (state_r == BUSY);
  assign stall      = (state_r == BUSY);
  assign imem_addr  = imem_addr_r;
  assign inst       = ir_r;
  assign inst_valid = inst_valid_r;
  assign pc         = pc_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pc_ld;
  logic        ir_ld;
  logic        pc_branch;
  logic [7:0]  branch_addr;
  logic        flush;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] inst;
  logic [7:0]  pc;
  logic        inst_valid;
  logic        stall;

  int checks_r = 0;
  int errors_r = 0;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc_ld      (pc_ld),
    .ir_ld      (ir_ld),
    .pc_branch  (pc_branch),
    .branch_addr(branch_addr),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .pc         (pc),
    .inst_valid (inst_valid),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_r++;
    if (obs !== exp_v) begin
      errors_r++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_ld = 1'b0; ir_ld = 1'b0; pc_branch = 1'b0; branch_addr = 8'h00;
    flush = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_req", 32'(imem_req), 32'h0);
    check_eq("rst_addr", 32'(imem_addr), 32'h00);
    check_eq("rst_stall", 32'(stall), 32'h0);
    check_eq("rst_pc", 32'(pc), 32'h00);
    check_eq("rst_inst", 32'(inst), 32'hF000);
    check_eq("rst_valid", 32'(inst_valid), 32'h0);

    // minimum-latency fetch with PC advance
    ir_ld = 1'b1; pc_ld = 1'b1;
    tick();
    idle_inputs();
    check_eq("f1_stall", 32'(stall), 32'h1);
    check_eq("f1_req", 32'(imem_req), 32'h1);
    check_eq("f1_addr", 32'(imem_addr), 32'h00);
    imem_ack = 1'b1; imem_rdata = 16'h1234;
    tick();
    idle_inputs();
    check_eq("f1_inst", 32'(inst), 32'h1234);
    check_eq("f1_valid", 32'(inst_valid), 32'h1);
    check_eq("f1_pc", 32'(pc), 32'h01);
    check_eq("f1_stall_end", 32'(stall), 32'h0);

    // ack delayed to the third busy cycle, no PC advance
    ir_ld = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check_eq("f2_stall", 32'(stall), 32'h1);
      check_eq("f2_req", 32'(imem_req), 32'h1);
      check_eq("f2_addr", 32'(imem_addr), 32'h01);
      if (i == 2) begin
        imem_ack = 1'b1; imem_rdata = 16'hABCD;
      end
      tick();
      idle_inputs();
    end
    check_eq("f2_stall_end", 32'(stall), 32'h0);
    check_eq("f2_inst", 32'(inst), 32'hABCD);
    check_eq("f2_pc", 32'(pc), 32'h01);

    // idle branch beats simultaneous increment
    pc_branch = 1'b1; branch_addr = 8'hFF; pc_ld = 1'b1;
    tick();
    idle_inputs();
    check_eq("br_idle_pc", 32'(pc), 32'hFF);

    // PC wrap after fetch at FF
    ir_ld = 1'b1; pc_ld = 1'b1;
    tick();
    idle_inputs();
    check_eq("wrap_addr", 32'(imem_addr), 32'hFF);
    imem_ack = 1'b1; imem_rdata = 16'h1111;
    tick();
    idle_inputs();
    check_eq("wrap_pc", 32'(pc), 32'h00);
    check_eq("wrap_inst", 32'(inst), 32'h1111);

    // two branches during busy: the later target wins over increment
    ir_ld = 1'b1; pc_ld = 1'b1;
    tick();
    idle_inputs();
    pc_branch = 1'b1; branch_addr = 8'h20;
    tick();
    idle_inputs();
    pc_branch = 1'b1; branch_addr = 8'h40;
    tick();
    idle_inputs();
    check_eq("br_busy_hold_pc", 32'(pc), 32'h00);
    imem_ack = 1'b1; imem_rdata = 16'h2222;
    tick();
    idle_inputs();
    check_eq("br_busy_pc", 32'(pc), 32'h40);
    check_eq("br_busy_inst", 32'(inst), 32'h2222);

    // flush coinciding with ack
    ir_ld = 1'b1;
    tick();
    idle_inputs();
    flush = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h3333;
    tick();
    idle_inputs();
    check_eq("fl_ack_inst", 32'(inst), 32'hF000);
    check_eq("fl_ack_valid", 32'(inst_valid), 32'h0);
    check_eq("fl_ack_stall", 32'(stall), 32'h0);
    check_eq("fl_ack_pc", 32'(pc), 32'h40);

    // flush earlier in busy: stays busy, drops data, PC still advances
    ir_ld = 1'b1; pc_ld = 1'b1;
    tick();
    idle_inputs();
    flush = 1'b1;
    tick();
    idle_inputs();
    check_eq("fl_busy_stall", 32'(stall), 32'h1);
    imem_ack = 1'b1; imem_rdata = 16'h4444;
    tick();
    idle_inputs();
    check_eq("fl_busy_inst", 32'(inst), 32'hF000);
    check_eq("fl_busy_valid", 32'(inst_valid), 32'h0);
    check_eq("fl_busy_pc", 32'(pc), 32'h41);

    // valid fetch, then idle flush suppresses a simultaneous ir_ld
    ir_ld = 1'b1;
    tick();
    idle_inputs();
    imem_ack = 1'b1; imem_rdata = 16'h5555;
    tick();
    idle_inputs();
    check_eq("f3_inst", 32'(inst), 32'h5555);
    check_eq("f3_valid", 32'(inst_valid), 32'h1);
    flush = 1'b1; ir_ld = 1'b1;
    tick();
    idle_inputs();
    check_eq("fl_idle_stall", 32'(stall), 32'h0);
    check_eq("fl_idle_inst", 32'(inst), 32'hF000);
    check_eq("fl_idle_valid", 32'(inst_valid), 32'h0);

    // ack while idle is ignored
    imem_ack = 1'b1; imem_rdata = 16'h6666;
    tick();
    idle_inputs();
    check_eq("idle_ack_inst", 32'(inst), 32'hF000);
    check_eq("idle_ack_stall", 32'(stall), 32'h0);

    // reset mid-busy, then a stray ack
    ir_ld = 1'b1; pc_ld = 1'b1;
    tick();
    idle_inputs();
    check_eq("rb_busy", 32'(stall), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rb_req", 32'(imem_req), 32'h0);
    check_eq("rb_addr", 32'(imem_addr), 32'h00);
    check_eq("rb_pc", 32'(pc), 32'h00);
    check_eq("rb_inst", 32'(inst), 32'hF000);
    imem_ack = 1'b1; imem_rdata = 16'h7777;
    tick();
    idle_inputs();
    check_eq("rb_ack_inst", 32'(inst), 32'hF000);
    check_eq("rb_ack_valid", 32'(inst_valid), 32'h0);
    check_eq("rb_ack_pc", 32'(pc), 32'h00);
    check_eq("rb_ack_stall", 32'(stall), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 8, PC and instruction-address width.
REQ-002 Parameter INST_W, default 16, instruction width.
REQ-003 Parameter NOP_INST, default 16'hF000, IR value after reset or flush (opcode 4'b1111 = no-op).
REQ-004 clk  input  1  the block's only clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 pc_ld  input  1  request PC advance (from control unit).
REQ-007 ir_ld  input  1  request instruction fetch into IR (from control unit).
REQ-008 pc_branch  input  1  load PC from branch_addr.
REQ-009 branch_addr  input  PC_W  branch target.
REQ-010 flush  input  1  discard current and in-flight instruction.
REQ-011 imem_req  output  1  instruction-memory read request, held until ack.
REQ-012 imem_addr  output  PC_W  read address, stable while imem_req=1.
REQ-013 imem_ack  input  1  read data valid this cycle.
REQ-014 imem_rdata  input  INST_W  read data.
REQ-015 inst  output  INST_W  IR contents, feeds control unit.
REQ-016 pc  output  PC_W  current PC.
REQ-017 inst_valid  output  1  IR holds a fetched, unflushed instruction.
REQ-018 stall  output  1  fetch in progress; control unit must hold its state.

Function
REQ-019 FSM states: IDLE, BUSY; stall=1 exactly when in BUSY.
REQ-020 IDLE: ir_ld=1 and flush=0 -> imem_addr<=pc, capture pc_ld into inc_pend, go BUSY.
REQ-021 BUSY: imem_req=1 and imem_addr held until imem_ack=1; earliest ack is the cycle after entry (min fetch latency 2 cycles).
REQ-022 BUSY with imem_ack=1 and no drop pending: IR<=imem_rdata, inst_valid<=1, go IDLE.
REQ-023 On leaving BUSY, PC<=br_pend target if a branch is pending, else PC+1 if inc_pend, else unchanged.
REQ-024 IDLE without ir_ld: pc_branch=1 -> PC<=branch_addr; else pc_ld=1 -> PC<=PC+1.
REQ-025 pc_branch=1 with pc_ld=1 in the same cycle: branch wins.
REQ-026 pc_branch during BUSY: target captured in br_pend and applied at completion; a later branch in the same BUSY overwrites the earlier one.
REQ-027 PC arithmetic is modulo 2^PC_W; PC=8'hFF increments to 8'h00.
REQ-028 flush in IDLE: IR<=NOP_INST, inst_valid<=0; ir_ld in the same cycle is ignored.
REQ-029 flush in BUSY: set drop; stay BUSY until ack; on ack IR<=NOP_INST, inst_valid<=0; the PC update of REQ-023 still applies.
REQ-030 flush coinciding with imem_ack: flush wins, IR<=NOP_INST.
REQ-031 imem_ack while IDLE is ignored.

Reset
REQ-032 rst=1 at a clock edge: state<=IDLE, PC<=0, IR<=NOP_INST, inst_valid<=0, inc_pend/br_pend/drop cleared; this has priority over all inputs.
REQ-033 Reset during BUSY: imem_req low from the next cycle; a late ack is ignored per REQ-031.
REQ-034 Output values after reset: imem_req=0, imem_addr=0, stall=0, pc=0, inst=NOP_INST.

Structure
REQ-035 Shared package cpu_pkg holds PC_W, INST_W, NOP_INST, opcode constants (JMP=4'b1011, LDI=4'b1100), and the fetch FSM state enum.
REQ-036 One sub-module, pc_reg, holds the PC and its next-value mux (branch/increment/hold); the FSM and IR live in fetch_unit.

Verification
REQ-037 Reset, then ir_ld=pc_ld=1 and ack 1 cycle later with rdata=16'h1234 -> inst=16'h1234, inst_valid=1, pc=1, stall high for exactly 1 cycle.
REQ-038 Ack delayed 3 cycles -> imem_addr constant and imem_req=1 throughout, stall=1 for 3 cycles.
REQ-039 PC=8'hFF, fetch with pc_ld -> pc=8'h00 after ack.
REQ-040 pc_branch=1 with branch_addr=8'h40 during BUSY -> pc=8'h40 after ack, not PC+1.
REQ-041 flush asserted in the ack cycle -> inst=16'hF000, inst_valid=0.
REQ-042 rst mid-BUSY, then a stray ack -> IDLE, pc=0, inst=16'hF000, IR unchanged by the ack.
